// File: rtl/scoreboard_regfile.sv
// Multi-ported register file with a per-register pending-writeback scoreboard.
// Reads are combinational with same-cycle write bypass; register 0 is hardwired to zero.
module scoreboard_regfile #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NREAD  = 2,
   parameter int unsigned NWRITE = 2,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREAD*AW-1:0]      rd_addr,
   output logic [NREAD*XLEN-1:0]    rd_data,
   output logic [NREAD-1:0]         rd_busy,
   input  logic [NWRITE-1:0]        wr_en,
   input  logic [NWRITE*AW-1:0]     wr_addr,
   input  logic [NWRITE*XLEN-1:0]   wr_data,
   input  logic                     iss_en,
   input  logic [AW-1:0]            iss_addr,
   output logic                     iss_ok,
   output logic [NREGS-1:0]         busy_vec
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Per-register write resolution; the ascending scan lets the highest port win.
   logic [NREGS-1:0] wr_hit;
   logic [XLEN-1:0]  wr_val [NREGS];

   always_comb begin
      for (int r = 0; r < int'(NREGS); r++) begin
         wr_hit[r] = 1'b0;
         wr_val[r] = '0;
         for (int w = 0; w < int'(NWRITE); w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
               wr_hit[r] = 1'b1;
               wr_val[r] = wr_data[w*XLEN +: XLEN];
            end
         end
      end
   end

   for (genvar p = 0; p < int'(NREAD); p++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[p*AW +: AW];
      assign rd_data[p*XLEN +: XLEN] = (ra == '0)  ? '0         :
                                       wr_hit[ra] ? wr_val[ra] : regs_q[ra];
      assign rd_busy[p] = busy_q[ra] & ~wr_hit[ra];
   end

   // A pending producer may be replaced only when its writeback lands this cycle.
   assign iss_ok = iss_en & ((iss_addr == '0) | ~busy_q[iss_addr] | wr_hit[iss_addr]);

   always_comb begin
      busy_d = busy_q & ~wr_hit;
      if (iss_ok) busy_d[iss_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
         busy_q <= '0;
      end else begin
         for (int r = 1; r < int'(NREGS); r++) begin
            if (wr_hit[r]) regs_q[r] <= wr_val[r];
         end
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Bench for scoreboard_regfile: directed scenarios plus randomized traffic checked
// against an array-based reference model of the register file and scoreboard.
module tb_scoreboard_regfile;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned NREAD  = 2;
   localparam int unsigned NWRITE = 2;
   localparam int unsigned AW     = 5;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NREAD*AW-1:0]     rd_addr;
   logic [NREAD*XLEN-1:0]   rd_data;
   logic [NREAD-1:0]        rd_busy;
   logic [NWRITE-1:0]       wr_en;
   logic [NWRITE*AW-1:0]    wr_addr;
   logic [NWRITE*XLEN-1:0]  wr_data;
   logic                    iss_en;
   logic [AW-1:0]           iss_addr;
   logic                    iss_ok;
   logic [NREGS-1:0]        busy_vec;

   int n_tests = 0;
   int n_fail  = 0;

   bit [XLEN-1:0] m_regs [NREGS];
   bit            m_busy [NREGS];

   scoreboard_regfile #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NREAD  (NREAD),
      .NWRITE (NWRITE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .iss_ok   (iss_ok),
      .busy_vec (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: is address a written this cycle, and with which data (top port wins)?
   function automatic bit wr_hits(input bit [AW-1:0] a, output bit [XLEN-1:0] d);
      bit hit = 1'b0;
      d = '0;
      for (int w = int'(NWRITE) - 1; w >= 0; w--) begin
         if (!hit && wr_en[w] && wr_addr[w*AW +: AW] == a) begin
            hit = 1'b1;
            d   = wr_data[w*XLEN +: XLEN];
         end
      end
      return hit;
   endfunction

   function automatic bit [XLEN-1:0] exp_rd(input bit [AW-1:0] a);
      bit [XLEN-1:0] d;
      if (a == 0) return '0;
      if (wr_hits(a, d)) return d;
      return m_regs[a];
   endfunction

   function automatic bit exp_rd_busy(input bit [AW-1:0] a);
      bit [XLEN-1:0] d;
      if (a == 0) return 1'b0;
      return m_busy[a] && !wr_hits(a, d);
   endfunction

   function automatic bit exp_iss_ok();
      bit [XLEN-1:0] d;
      if (!iss_en) return 1'b0;
      return (iss_addr == 0) || !m_busy[iss_addr] || wr_hits(iss_addr, d);
   endfunction

   task automatic idle();
      rst_n    = 1'b1;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
   endtask

   task automatic settle_check();
      bit [NREGS-1:0] bv;
      #1;
      for (int r = 0; r < int'(NREGS); r++) bv[r] = m_busy[r];
      for (int p = 0; p < int'(NREAD); p++) begin
         check($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN],
               exp_rd(rd_addr[p*AW +: AW]));
         check($sformatf("rd_busy[%0d]", p), 32'(rd_busy[p]),
               32'(exp_rd_busy(rd_addr[p*AW +: AW])));
      end
      check("iss_ok", 32'(iss_ok), 32'(exp_iss_ok()));
      check("busy_vec", busy_vec, bv);
   endtask

   // Advance one clock and apply the same inputs to the model.
   task automatic tick();
      bit ok;
      ok = exp_iss_ok();
      @(posedge clk);
      if (!rst_n) begin
         for (int r = 0; r < int'(NREGS); r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
         end
      end else begin
         for (int w = 0; w < int'(NWRITE); w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
               m_regs[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
               m_busy[wr_addr[w*AW +: AW]] = 1'b0;
            end
         end
         if (ok && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NREGS - 1));
   endfunction

   initial begin
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      tick();

      // Post-reset state
      idle();
      iss_en   = 1'b1;
      iss_addr = 5'd12;
      rd_addr  = {5'd12, 5'd5};
      settle_check();
      check("reset iss_ok", 32'(iss_ok), 32'd1);
      check("reset busy_vec", busy_vec, 32'd0);
      check("reset rd_data", rd_data[31:0], 32'd0);
      idle();

      // Write then read on both ports
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
      settle_check(); tick(); idle();
      rd_addr = {5'd5, 5'd5};
      settle_check();
      check("r5 port0", rd_data[31:0], 32'hDEADBEEF);
      check("r5 port1", rd_data[63:32], 32'hDEADBEEF);
      check("r5 busy", 32'(rd_busy), 32'd0);
      tick(); idle();

      // Two ports writing one register: port 1 wins, with bypass
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd0, 5'd7};
      settle_check();
      check("r7 bypass", rd_data[31:0], 32'h22);
      tick(); idle();
      rd_addr = {5'd0, 5'd7};
      settle_check();
      check("r7 commit", rd_data[31:0], 32'h22);
      tick(); idle();

      // Register 0 is hardwired
      wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'h1234}; rd_addr = '0;
      settle_check();
      check("r0 read", rd_data[31:0], 32'd0);
      tick(); idle();
      iss_en = 1'b1; iss_addr = 5'd0;
      settle_check();
      check("r0 iss_ok", 32'(iss_ok), 32'd1);
      tick(); idle();
      settle_check();
      check("r0 busy_vec", busy_vec, 32'd0);

      // WAW hazard and writeback clearing
      iss_en = 1'b1; iss_addr = 5'd3;
      settle_check(); tick(); idle();
      iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd0, 5'd3};
      settle_check();
      check("r3 busy_vec", 32'(busy_vec[3]), 32'd1);
      check("r3 reissue", 32'(iss_ok), 32'd0);
      check("r3 rd_busy", 32'(rd_busy[0]), 32'd1);
      tick(); idle();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h55}; rd_addr = {5'd0, 5'd3};
      settle_check();
      check("r3 wb rd_busy", 32'(rd_busy[0]), 32'd0);
      check("r3 wb rd_data", rd_data[31:0], 32'h55);
      tick(); idle();
      settle_check();
      check("r3 cleared", 32'(busy_vec[3]), 32'd0);

      // Same-cycle issue and writeback: new producer wins
      iss_en = 1'b1; iss_addr = 5'd9;
      settle_check(); tick(); idle();
      iss_en = 1'b1; iss_addr = 5'd9;
      wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'hAA, 32'd0};
      settle_check();
      check("r9 iss_ok", 32'(iss_ok), 32'd1);
      tick(); idle();
      rd_addr = {5'd0, 5'd9};
      settle_check();
      check("r9 busy_vec", 32'(busy_vec[9]), 32'd1);
      check("r9 rd_data", rd_data[31:0], 32'hAA);
      check("r9 rd_busy", 32'(rd_busy[0]), 32'd1);
      tick(); idle();

      // Mid-operation reset drops everything
      iss_en = 1'b1; iss_addr = 5'd4;
      settle_check(); tick(); idle();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'd0, 32'h77};
      settle_check(); tick(); idle();
      rst_n = 1'b0;
      settle_check(); tick(); idle();
      rd_addr = {5'd6, 5'd4};
      settle_check();
      check("rst busy_vec", busy_vec, 32'd0);
      check("rst r4", rd_data[31:0], 32'd0);
      check("rst r6", rd_data[63:32], 32'd0);
      tick();

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         for (int p = 0; p < int'(NREAD); p++) rd_addr[p*AW +: AW] = rand_addr();
         for (int w = 0; w < int'(NWRITE); w++) begin
            wr_en[w]                 = ($urandom_range(0, 2) == 0);
            wr_addr[w*AW +: AW]      = rand_addr();
            wr_data[w*XLEN +: XLEN]  = $urandom;
         end
         iss_en   = ($urandom_range(0, 1) == 1);
         iss_addr = rand_addr();
         settle_check();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of every register.
REQ-002 Parameter NREGS, default 32, register count; power of two, >= 2.
REQ-003 Parameter NREAD, default 2, number of independent read ports, >= 1.
REQ-004 Parameter NWRITE, default 2, number of independent write ports, >= 1.
REQ-005 Derived AW = clog2(NREGS), register address width.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 rd_addr  in  NREAD*AW  read addresses, port p at bits [p*AW +: AW].
REQ-009 rd_data  out  NREAD*XLEN  read data, port p at bits [p*XLEN +: XLEN].
REQ-010 rd_busy  out  NREAD  per read port: source register still awaits a writeback.
REQ-011 wr_en  in  NWRITE  per write-port enable.
REQ-012 wr_addr  in  NWRITE*AW  write addresses.
REQ-013 wr_data  in  NWRITE*XLEN  write data.
REQ-014 iss_en  in  1  issue request; marks iss_addr as pending producer.
REQ-015 iss_addr  in  AW  destination register of the issue.
REQ-016 iss_ok  out  1  issue accepted this cycle (no WAW hazard).
REQ-017 busy_vec  out  NREGS  current scoreboard state, bit r = register r pending.

Function
REQ-018 Register 0 SHALL read as zero on every port; writes to it are discarded; busy bit 0 is constant 0.
REQ-019 Writes SHALL commit at the rising edge when wr_en[w]=1 and wr_addr[w]!=0.
REQ-020 Multiple write ports to the same address in one cycle: highest-numbered port wins, for both commit and bypass.
REQ-021 Reads SHALL be combinational, zero-cycle latency, with write-through bypass: a same-cycle enabled write to rd_addr[p] (nonzero) drives rd_data[p] with that write's data.
REQ-022 rd_busy[p] = busy[rd_addr[p]] AND NOT (any wr_en[w] with wr_addr[w]=rd_addr[p]); 0 for address 0.
REQ-023 iss_ok = iss_en AND (iss_addr=0 OR NOT busy[iss_addr] OR same-cycle write to iss_addr), combinational.
REQ-024 iss_en with iss_ok=0 SHALL be ignored: no state change from the issue.
REQ-025 Busy bit r next-state per edge: set if iss_ok and iss_addr=r (r!=0); else cleared if any write to r; else hold.
REQ-026 Same-cycle issue and write to r: write commits data, busy[r] ends set (new producer wins).
REQ-027 Write to a non-busy register SHALL commit data and leave busy unchanged (0).
REQ-028 busy_vec SHALL reflect registered state only (no same-cycle bypass).
REQ-029 Addresses >= NREGS cannot occur (NREGS power of two); no range checking.

Reset
REQ-030 While rst_n=0 at a rising edge, all registers clear to 0 and all busy bits clear to 0; writes and issues in that cycle are discarded.
REQ-031 Reset values observed after the edge: rd_data = 0 (absent bypass), rd_busy = 0, busy_vec = 0, iss_ok = iss_en.
REQ-032 Reset asserted mid-operation SHALL drop all pending busy bits; no partial state survives.

Verification
REQ-033 After reset, write 0xDEADBEEF to r5 via port 0, next cycle read r5 on ports 0 and 1 -> both 0xDEADBEEF, rd_busy=0.
REQ-034 Same cycle: wr port 0 r7=0x11, port 1 r7=0x22, read r7 -> rd_data=0x22 that cycle; next cycle r7 reads 0x22.
REQ-035 Write 0x1234 to r0, read r0 -> 0; issue r0 -> iss_ok=1, busy_vec unchanged (bit 0 = 0).
REQ-036 Issue r3 -> busy_vec[3]=1; re-issue r3 -> iss_ok=0; read r3 -> rd_busy=1; write r3=0x55 -> rd_busy=0 and rd_data=0x55 same cycle, busy_vec[3]=0 next cycle.
REQ-037 busy_vec[9]=1; same cycle issue r9 and write r9=0xAA -> iss_ok=1; next cycle busy_vec[9]=1, r9 reads 0xAA with rd_busy=1.
REQ-038 Issue r4, write r6=0x77, then rst_n=0 one cycle -> busy_vec=0, r4 and r6 read 0.
